// File: rtl/ws2812_pkg.sv
// Shared definitions for the WS2812 chain controller: SFR addresses, CTRL bit
// positions, controller state encoding and the channel brightness helper.
package ws2812_pkg;

  localparam logic [7:0] ADDR_CTRL   = 8'hC2;
  localparam logic [7:0] ADDR_RED    = 8'hC3;
  localparam logic [7:0] ADDR_GREEN  = 8'hC4;
  localparam logic [7:0] ADDR_BLUE   = 8'hC5;
  localparam logic [7:0] ADDR_INDEX  = 8'hC6;
  localparam logic [7:0] ADDR_BRIGHT = 8'hC7;

  localparam int CTRL_GO_BIT   = 0;
  localparam int CTRL_AUTO_BIT = 1;
  localparam int CTRL_BUSY_BIT = 7;

  localparam logic [7:0] BRIGHT_RESET = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_LATCH = 2'd3
  } ws2812_state_e;

  // (c*b + c) >> 8 : b=0xFF gives c back exactly, b=0x00 gives 0.
  function automatic logic [7:0] scale_chan(input logic [7:0] c, input logic [7:0] b);
    logic [15:0] p;
    p = 16'(c) * 16'(b) + 16'(c);
    return p[15:8];
  endfunction

endpackage

// File: rtl/ws2812_bit_tx.sv
// WS2812 bit serialiser: sends one 24-bit word MSB first with per-bit
// high times T0H/T1H inside a TBIT-cycle period.
//
// Handshake: start is a one-cycle pulse that loads word and begins sending
// (it may arrive while the previous word is in its final cycle, giving a
// seamless chain). done pulses for one cycle two cycles before the last bit
// period ends on dout, so an upstream LOAD cycle can issue the next start
// with no gap between words.
module ws2812_bit_tx
  import ws2812_pkg::*;
#(
  parameter int T0H  = 20,
  parameter int T1H  = 40,
  parameter int TBIT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [23:0] word,
  output logic        done,
  output logic        dout
);

  localparam int CNT_W = $clog2(TBIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TBIT - 1);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(TBIT - 2);
  localparam logic [CNT_W-1:0] HI0      = CNT_W'(T0H);
  localparam logic [CNT_W-1:0] HI1      = CNT_W'(T1H);

  logic [23:0]      shreg_q;
  logic [CNT_W-1:0] cnt_q;
  logic [4:0]       bit_idx_q;
  logic             active_q;

  assign done = active_q && (bit_idx_q == 5'd0) && (cnt_q == CNT_DONE);

  // Bit-period counter and shift register; start has priority over finishing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg_q   <= '0;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      active_q  <= 1'b0;
    end else if (start) begin
      shreg_q   <= word;
      cnt_q     <= '0;
      bit_idx_q <= 5'd23;
      active_q  <= 1'b1;
    end else if (active_q) begin
      if (cnt_q == CNT_LAST) begin
        cnt_q <= '0;
        if (bit_idx_q == 5'd0) begin
          active_q <= 1'b0;
        end else begin
          bit_idx_q <= bit_idx_q - 5'd1;
          shreg_q   <= {shreg_q[22:0], 1'b0};
        end
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  // Registered line level: high for the first T0H/T1H offsets of each period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout <= 1'b0;
    end else begin
      dout <= active_q && (shreg_q[23] ? (cnt_q < HI1) : (cnt_q < HI0));
    end
  end

endmodule

// File: rtl/ws2812_chain_ctrl.sv
// WS2812 chain controller with an 8051 SFR interface. Pixels are written
// through RED/GREEN/BLUE/INDEX into a frame buffer and streamed on dout
// followed by a latch-low gap. Optional global brightness is enabled with
// the macro WS2812_BRIGHTNESS_EN.
module ws2812_chain_ctrl
  import ws2812_pkg::*;
#(
  parameter int NUM_LEDS = 8,
  parameter int T0H      = 20,
  parameter int T1H      = 40,
  parameter int TBIT     = 64,
  parameter int TRESET   = 3000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] sfr_addr,
  input  logic       sfr_wr,
  input  logic       sfr_rd,
  input  logic [7:0] sfr_data_in,
  output logic [7:0] sfr_data_out,
  output logic       sfr_cs,
  output logic       dout,
  output logic       busy,
  output logic [1:0] state_dbg
);

  localparam int IDX_W = $clog2(NUM_LEDS);
  localparam int LAT_W = $clog2(TRESET);
  localparam logic [IDX_W-1:0] LED_LAST = IDX_W'(NUM_LEDS - 1);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(TRESET - 1);

  ws2812_state_e    state_q, state_d;
  logic [IDX_W-1:0] led_q;
  logic [LAT_W-1:0] lat_cnt_q;
  logic             pending_q;
  logic [7:0]       red_q, green_q, blue_q, index_q;
  logic             auto_q;
  logic [23:0]      buffer_q [NUM_LEDS];
  logic [23:0]      tx_word;
  logic             tx_done;
  logic             hit_ctrl, hit_red, hit_green, hit_blue, hit_index;
  logic             go_wr, blue_wr;
  logic [7:0]       rd_data;

  assign hit_ctrl  = (sfr_addr == ADDR_CTRL);
  assign hit_red   = (sfr_addr == ADDR_RED);
  assign hit_green = (sfr_addr == ADDR_GREEN);
  assign hit_blue  = (sfr_addr == ADDR_BLUE);
  assign hit_index = (sfr_addr == ADDR_INDEX);
  assign go_wr     = sfr_wr && hit_ctrl && sfr_data_in[CTRL_GO_BIT];
  assign blue_wr   = sfr_wr && hit_blue;
  assign state_dbg = state_q;

`ifdef WS2812_BRIGHTNESS_EN
  logic       hit_bright;
  logic [7:0] bright_q;
  logic [23:0] pix;
  assign hit_bright = (sfr_addr == ADDR_BRIGHT);
  assign sfr_cs     = hit_ctrl | hit_red | hit_green | hit_blue | hit_index | hit_bright;
  assign pix        = buffer_q[led_q];
  assign tx_word    = {scale_chan(pix[23:16], bright_q), scale_chan(pix[15:8], bright_q),
                       scale_chan(pix[7:0], bright_q)};

  // Brightness register, identity at reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bright_q <= BRIGHT_RESET;
    end else if (sfr_wr && hit_bright) begin
      bright_q <= sfr_data_in;
    end
  end
`else
  assign sfr_cs  = hit_ctrl | hit_red | hit_green | hit_blue | hit_index;
  assign tx_word = buffer_q[led_q];
`endif

  // Read mux; reads are side-effect free and gated by sfr_rd.
  always_comb begin
    rd_data = '0;
    if (hit_ctrl) begin
      rd_data[CTRL_AUTO_BIT] = auto_q;
      rd_data[CTRL_BUSY_BIT] = busy;
    end else if (hit_red) begin
      rd_data = red_q;
    end else if (hit_green) begin
      rd_data = green_q;
    end else if (hit_blue) begin
      rd_data = blue_q;
    end else if (hit_index) begin
      rd_data = index_q;
    end
`ifdef WS2812_BRIGHTNESS_EN
    else if (hit_bright) begin
      rd_data = bright_q;
    end
`endif
    sfr_data_out = sfr_rd ? rd_data : 8'h00;
  end

  // Colour/index/control registers; BLUE write commits a pixel and steps INDEX.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      red_q   <= '0;
      green_q <= '0;
      blue_q  <= '0;
      index_q <= '0;
      auto_q  <= 1'b0;
    end else if (sfr_wr) begin
      if (hit_ctrl) auto_q <= sfr_data_in[CTRL_AUTO_BIT];
      if (hit_red) red_q <= sfr_data_in;
      if (hit_green) green_q <= sfr_data_in;
      if (hit_blue) begin
        blue_q  <= sfr_data_in;
        index_q <= (index_q == 8'(NUM_LEDS - 1)) ? 8'd0 : index_q + 8'd1;
      end
      if (hit_index && ({1'b0, sfr_data_in} < 9'(NUM_LEDS))) index_q <= sfr_data_in;
    end
  end

  // Frame buffer, one {G,R,B} word per LED.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_LEDS; i++) buffer_q[i] <= '0;
    end else if (blue_wr) begin
      buffer_q[index_q[IDX_W-1:0]] <= {green_q, red_q, sfr_data_in};
    end
  end

  // Next-state logic for the frame sequencer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (go_wr || auto_q || pending_q) state_d = ST_LOAD;
      ST_LOAD:  state_d = ST_SHIFT;
      ST_SHIFT: if (tx_done) state_d = (led_q == LED_LAST) ? ST_LATCH : ST_LOAD;
      ST_LATCH: if (lat_cnt_q == LAT_LAST)
                  state_d = (pending_q || go_wr || auto_q) ? ST_LOAD : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Sequencer state, LED pointer, latch timer, sticky GO and busy flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      led_q     <= '0;
      lat_cnt_q <= '0;
      pending_q <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q <= state_d;
      busy    <= (state_d != ST_IDLE);
      if (state_d == ST_LOAD) led_q <= (state_q == ST_SHIFT) ? led_q + IDX_W'(1) : '0;
      lat_cnt_q <= (state_q == ST_LATCH) ? lat_cnt_q + LAT_W'(1) : '0;
      if (state_q == ST_LATCH && state_d == ST_LOAD) pending_q <= 1'b0;
      else if (go_wr && state_q != ST_IDLE) pending_q <= 1'b1;
    end
  end

  ws2812_bit_tx #(
    .T0H  (T0H),
    .T1H  (T1H),
    .TBIT (TBIT)
  ) u_bit_tx (
    .clk   (clk),
    .rst   (rst),
    .start (state_q == ST_LOAD),
    .word  (tx_word),
    .done  (tx_done),
    .dout  (dout)
  );

endmodule
